// File: rtl/core_seq_ctrl_pkg.sv
// Shared definitions for the core pipeline sequencer: state encoding and
// default widths.
package core_seq_ctrl_pkg;

    localparam int IDX_W_DEF = 3;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } seq_state_e;

endpackage

// File: rtl/core_seq_ctrl_hazard_detect.sv
// Read-after-write comparator: flags an ID source that matches a pending
// write in EX or WB.
module hazard_detect #(
    parameter int IDX_W = 3
) (
    input  logic             valid_id,
    input  logic [IDX_W-1:0] op1_id,
    input  logic [IDX_W-1:0] op2_id,
    input  logic             use1_id,
    input  logic             use2_id,
    input  logic [IDX_W-1:0] op0_ex,
    input  logic [IDX_W-1:0] op0_wb,
    input  logic             wr_ex,
    input  logic             wr_wb,
    output logic             hazard
);

    logic hit_ex, hit_wb;

    // wr_* already folds in the stage valid bit, so bubbles never match
    assign hit_ex = wr_ex && ((use1_id && op1_id == op0_ex) || (use2_id && op2_id == op0_ex));
    assign hit_wb = wr_wb && ((use1_id && op1_id == op0_wb) || (use2_id && op2_id == op0_wb));
    assign hazard = valid_id && (hit_ex || hit_wb);

endmodule

// File: rtl/core_seq_ctrl.sv
// Four-stage pipeline sequencer: run/step/halt FSM, stage enables/flushes,
// valid tracking and optional perf counters (CORE_SEQ_PERF_EN).
module core_seq_ctrl
    import core_seq_ctrl_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic             halt_ex,
    input  logic             redirect_wb,
    input  logic [IDX_W-1:0] op1_id,
    input  logic [IDX_W-1:0] op2_id,
    input  logic             use1_id,
    input  logic             use2_id,
    input  logic [IDX_W-1:0] op0_ex,
    input  logic [IDX_W-1:0] op0_wb,
    input  logic             regWrite_ex,
    input  logic             regWrite_wb,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] stalls
);

    seq_state_e state_q, state_n;
    logic valid_id, valid_ex, valid_wb;
    logic advance, halt_hit, hazard, stall_cyc;

    hazard_detect #(.IDX_W(IDX_W)) u_hazard (
        .valid_id (valid_id),
        .op1_id   (op1_id),
        .op2_id   (op2_id),
        .use1_id  (use1_id),
        .use2_id  (use2_id),
        .op0_ex   (op0_ex),
        .op0_wb   (op0_wb),
        .wr_ex    (regWrite_ex && valid_ex),
        .wr_wb    (regWrite_wb && valid_wb),
        .hazard   (hazard)
    );

    always_comb begin
        state_n     = state_q;
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_we    = 1'b0;
        ex_wb_we    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        stall_cyc   = 1'b0;
        advance     = (state_q == RUN) || (state_q == STEP);
        halt_hit    = halt_ex && valid_ex;

        if (advance) begin
            if (halt_hit) begin
                // Drain HALT into WB while bubbling everything younger
                if_id_we    = 1'b1;
                id_ex_we    = 1'b1;
                ex_wb_we    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (redirect_wb) begin
                pc_we       = 1'b1;
                if_id_we    = 1'b1;
                id_ex_we    = 1'b1;
                ex_wb_we    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (hazard) begin
                // Hold PC and IF/ID, inject a bubble into EX
                id_ex_we    = 1'b1;
                id_ex_flush = 1'b1;
                ex_wb_we    = 1'b1;
                stall_cyc   = 1'b1;
            end else begin
                pc_we    = 1'b1;
                if_id_we = 1'b1;
                id_ex_we = 1'b1;
                ex_wb_we = 1'b1;
            end
        end

        case (state_q)
            IDLE:    if (run_req) state_n = RUN;
                     else if (step_req) state_n = STEP;
            RUN:     if (halt_hit) state_n = HALT;
                     else if (halt_req || !run_req) state_n = IDLE;
            STEP:    state_n = IDLE;
            HALT:    if (run_req) state_n = RUN;
                     else if (step_req) state_n = STEP;
            default: state_n = IDLE;
        endcase
    end

    assign state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            valid_id <= 1'b0;
            valid_ex <= 1'b0;
            valid_wb <= 1'b0;
        end else begin
            state_q <= state_n;
            if (if_id_we) valid_id <= pc_we && !if_id_flush;
            if (id_ex_we) valid_ex <= valid_id && !id_ex_flush;
            if (ex_wb_we) valid_wb <= valid_ex;
        end
    end

`ifdef CORE_SEQ_PERF_EN
    logic [CNT_W-1:0] retired_q, stalls_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_q <= '0;
            stalls_q  <= '0;
        end else begin
            if (advance && valid_wb) retired_q <= retired_q + 1'b1;
            if (stall_cyc)           stalls_q  <= stalls_q + 1'b1;
        end
    end

    assign retired = retired_q;
    assign stalls  = stalls_q;
`else
    assign retired = '0;
    assign stalls  = '0;
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: expectations are queued as stimulus is
// applied and popped against DUT outputs once they settle.
module tb_core_seq_ctrl;
    import core_seq_ctrl_pkg::*;

    localparam int IDX_W = 3;
    localparam int CNT_W = 16;
`ifdef CORE_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, run_req, step_req, halt_req, halt_ex, redirect_wb;
    logic [IDX_W-1:0] op1_id, op2_id, op0_ex, op0_wb;
    logic use1_id, use2_id, regWrite_ex, regWrite_wb;
    logic pc_we, if_id_we, id_ex_we, ex_wb_we, if_id_flush, id_ex_flush;
    logic [1:0] state;
    logic [CNT_W-1:0] retired, stalls;

    always #5 clk = ~clk;

    core_seq_ctrl #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req),
        .halt_req(halt_req), .halt_ex(halt_ex), .redirect_wb(redirect_wb),
        .op1_id(op1_id), .op2_id(op2_id), .use1_id(use1_id), .use2_id(use2_id),
        .op0_ex(op0_ex), .op0_wb(op0_wb), .regWrite_ex(regWrite_ex),
        .regWrite_wb(regWrite_wb), .pc_we(pc_we), .if_id_we(if_id_we),
        .id_ex_we(id_ex_we), .ex_wb_we(ex_wb_we), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .state(state), .retired(retired), .stalls(stalls)
    );

    // ctrl vector: {state, pc_we, if_id_we, id_ex_we, ex_wb_we, if_id_flush, id_ex_flush}
    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
        logic [15:0] mask;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [5:0] C_NORM  = 6'b111100;
    localparam logic [5:0] C_ZERO  = 6'b000000;
    localparam logic [5:0] C_REDIR = 6'b111111;
    // halt drain: pc_we=0, ex_wb_we=1, both flushes 1
    localparam logic [5:0] C_HALT  = 6'b000111;
    localparam logic [5:0] M_HALT  = 6'b100111;
    // hazard stall: pc_we=0, if_id_we=0, ex_wb_we=1, id_ex_flush=1
    localparam logic [5:0] C_STALL = 6'b000101;
    localparam logic [5:0] M_STALL = 6'b110101;

    function automatic logic [15:0] observe(int sel);
        case (sel)
            0:       return {8'h0, state, pc_we, if_id_we, id_ex_we, ex_wb_we, if_id_flush, id_ex_flush};
            1:       return retired;
            default: return stalls;
        endcase
    endfunction

    task automatic push_ctrl(string tag, seq_state_e st, logic [5:0] bits, logic [5:0] m);
        exp_t e;
        e.tag = tag; e.sel = 0; e.val = {8'h0, st, bits}; e.mask = {8'h0, 2'b11, m};
        sb.push_back(e);
    endtask

    task automatic push_cnt(string tag, int sel, logic [15:0] v);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = PERF ? v : 16'h0; e.mask = 16'hffff;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [15:0] o;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sel) & e.mask;
            n_cmp++;
            assert (o === (e.val & e.mask))
            else begin
                n_bad++;
                $error("FAIL %s: observed %h expected %h", e.tag, o, e.val & e.mask);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; run_req = 0; step_req = 0; halt_req = 0; halt_ex = 0; redirect_wb = 0;
        op1_id = 0; op2_id = 0; op0_ex = 0; op0_wb = 0;
        use1_id = 0; use2_id = 0; regWrite_ex = 0; regWrite_wb = 0;

        tick();
        push_ctrl("reset_ctrl", IDLE, C_ZERO, 6'h3f);
        push_cnt("reset_retired", 1, 16'd0);
        push_cnt("reset_stalls", 2, 16'd0);
        drain();
        rst = 1'b0;
        tick();

        // Run with independent instructions: 3 fill cycles then retire each cycle
        run_req = 1'b1;
        push_ctrl("idle_frozen", IDLE, C_ZERO, 6'h3f);
        drain();
        tick();
        for (int i = 0; i < 10; i++) begin
            push_ctrl("run_normal", RUN, C_NORM, 6'h3f);
            drain();
            tick();
        end
        push_cnt("fill_retired", 1, 16'd7);
        drain();

        // Source indices that match but are not read must not stall
        op2_id = 3'd3; use2_id = 1'b0; op0_ex = 3'd3; regWrite_ex = 1'b1;
        push_ctrl("unused_src", RUN, C_NORM, 6'h3f);
        drain();
        op2_id = 3'd0;

        // EX dependency: stall in EX, then the producer moves to WB and stalls again
        use1_id = 1'b1; op1_id = 3'd3;
        push_ctrl("haz_ex", RUN, C_STALL, M_STALL);
        drain();
        tick();
        op0_ex = 3'd0; regWrite_ex = 1'b0; op0_wb = 3'd3; regWrite_wb = 1'b1;
        push_ctrl("haz_wb", RUN, C_STALL, M_STALL);
        drain();
        tick();
        op0_wb = 3'd0; regWrite_wb = 1'b0;
        push_ctrl("haz_clear", RUN, C_NORM, 6'h3f);
        push_cnt("stall_count", 2, 16'd2);
        drain();
        use1_id = 1'b0; op1_id = 3'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            push_ctrl("refill1", RUN, C_NORM, 6'h3f);
            drain();
        end

        // Redirect: squash younger; a stale EX match must then be ignored
        redirect_wb = 1'b1;
        push_ctrl("redirect", RUN, C_REDIR, 6'h3f);
        drain();
        tick();
        redirect_wb = 1'b0;
        use1_id = 1'b1; op1_id = 3'd5; op0_ex = 3'd5; regWrite_ex = 1'b1;
        push_ctrl("post_redirect", RUN, C_NORM, 6'h3f);
        drain();
        use1_id = 1'b0; op1_id = 3'd0; op0_ex = 3'd0; regWrite_ex = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            push_ctrl("refill2", RUN, C_NORM, 6'h3f);
            drain();
        end

        // halt_ex wins over redirect_wb and over a coincident halt_req
        halt_ex = 1'b1; redirect_wb = 1'b1; halt_req = 1'b1;
        push_ctrl("halt_drain", RUN, C_HALT, M_HALT);
        drain();
        tick();
        halt_ex = 1'b0; redirect_wb = 1'b0; halt_req = 1'b0; run_req = 1'b0;
        push_ctrl("halted", HALT, C_ZERO, 6'h3f);
        drain();
        tick();
        push_ctrl("halt_hold", HALT, C_ZERO, 6'h3f);
        drain();
        run_req = 1'b1;
        tick();
        push_ctrl("resume", RUN, C_NORM, 6'h3f);
        drain();

        // halt_req pulse returns to IDLE
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0; run_req = 1'b0;
        push_ctrl("halt_req_idle", IDLE, C_ZERO, 6'h3f);
        drain();

        // Three single steps from IDLE
        for (int i = 0; i < 3; i++) begin
            step_req = 1'b1;
            push_ctrl("step_pre", IDLE, C_ZERO, 6'h3f);
            drain();
            tick();
            step_req = 1'b0;
            push_ctrl("step_adv", STEP, C_NORM, 6'h3f);
            drain();
            tick();
            push_ctrl("step_done", IDLE, C_ZERO, 6'h3f);
            drain();
        end

        // run_req beats step_req; step_req ignored while running
        run_req = 1'b1; step_req = 1'b1;
        tick();
        push_ctrl("run_prio", RUN, C_NORM, 6'h3f);
        drain();
        tick();
        step_req = 1'b0;
        push_ctrl("step_ignored", RUN, C_NORM, 6'h3f);
        drain();

        // Fresh run to retired=5, then async reset mid-RUN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) tick();
        push_ctrl("pre_rst_run", RUN, C_NORM, 6'h3f);
        push_cnt("pre_rst_retired", 1, 16'd5);
        push_cnt("pre_rst_stalls", 2, 16'd0);
        drain();
        rst = 1'b1;
        push_ctrl("mid_rst_ctrl", IDLE, C_ZERO, 6'h3f);
        push_cnt("mid_rst_retired", 1, 16'd0);
        push_cnt("mid_rst_stalls", 2, 16'd0);
        drain();
        tick();
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/core_seq_ctrl.md
# core_seq_ctrl

Pipeline sequencer for the four-stage core (IF, ID, EX, WB). It owns the enable and flush of the PC register and the three inter-stage registers, and detects register read-after-write hazards. It also runs the run/step/halt debug state machine and tracks stage valid bits for retirement counting. It sits beside the datapath and drives only control; no data passes through it.

## Interface
- IDX_W, 3, register index width
- CNT_W, 16, retire/stall counter width
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- run_req  in  1  level; request continuous execution
- step_req  in  1  pulse; advance pipeline exactly one cycle
- halt_req  in  1  pulse; stop after current cycle
- halt_ex  in  1  HALT instruction in EX
- redirect_wb  in  1  PC redirect (taken branch/jump) in WB
- op1_id, op2_id  in  IDX_W  source indices in ID
- use1_id, use2_id  in  1  source actually read
- op0_ex, op0_wb  in  IDX_W  destination indices
- regWrite_ex, regWrite_wb  in  1  destination write enables
- pc_we, if_id_we, id_ex_we, ex_wb_we  out  1  register enables
- if_id_flush, id_ex_flush  out  1  load bubble (control fields zero)
- state  out  2  IDLE=0, RUN=1, STEP=2, HALT=3
- retired  out  CNT_W  instructions retired from WB
- stalls  out  CNT_W  hazard stall cycles

## Operation
- Internal valid_id, valid_ex, valid_wb. They shift on enable. A flush or bubble clears the destination valid bit. The PC feeds valid_id=1 whenever pc_we.
- Transitions:
  - IDLE->RUN on run_req.
  - IDLE/HALT->STEP on step_req.
  - STEP->IDLE after exactly one cycle.
  - RUN->IDLE on halt_req or when run_req drops.
  - RUN->HALT when halt_ex && valid_ex.
  - HALT->RUN on run_req.
  - run_req has priority over step_req.
- In IDLE and HALT, all enables and flushes are 0; the pipeline is frozen.
- In RUN/STEP ("advance"), priority rst > halt_ex > redirect_wb > hazard > normal.
- halt_ex: pc_we=0, if_id_flush=1, id_ex_flush=1, ex_wb_we=1. This drains HALT to WB.
- redirect_wb: all enables 1, if_id_flush=1, id_ex_flush=1. Younger instructions are squashed, and the PC loads the target.
- Hazard occurs when valid_id and (use1_id && op1_id==op0_x) or (use2_id && op2_id==op0_x) matches a valid stage x in {ex, wb} with regWrite_x=1.
- On hazard: pc_we=0, if_id_we=0, id_ex_flush=1, ex_wb_we=1, and stalls+1.
- Normal: all four enables 1, flushes 0.
- Counters: retired+1 on any advancing cycle with valid_wb=1. Counters wrap modulo 2^CNT_W.

## Timing
- Enables and flushes are combinational from state, valid bits and ID/EX/WB inputs. There are no registered outputs except state, valid bits and counters.
- Reset: state=IDLE, valid bits 0, retired=0, stalls=0, all enables and flushes 0.
- Reset asserted mid-RUN clears everything in the same cycle (async).
- step_req is sampled in IDLE/HALT only and ignored elsewhere. A STEP cycle applies the full hazard/redirect/halt rules.
- A WB match stalls 1 cycle; an EX match stalls 2 cycles.
- halt_ex and redirect_wb in the same cycle are resolved as halt_ex.
- halt_req coincident with halt_ex gives HALT.

## Configuration
- CORE_SEQ_PERF_EN defined: retired and stalls counters are implemented.
- CORE_SEQ_PERF_EN undefined: both outputs are constant 0, there are no counter flops, and sequencing is otherwise identical.

## Structure
- The shared package holds the state encoding constants (IDLE, RUN, STEP, HALT) and the default IDX_W and CNT_W.
- One sub-module, hazard_detect: a combinational index comparator producing the hazard signal. The FSM, valid tracking and counters stay in core_seq_ctrl.

## Test plan
- Reset then run_req=1 with independent instructions: all enables 1 from the first RUN cycle. After 10 cycles, retired=7 (three fill cycles).
- EX-dependent instruction (op1_id=op0_ex=3, regWrite_ex=1): two cycles with pc_we=0 and id_ex_flush=1, then stalls=2.
- redirect_wb pulse: both flushes 1 for one cycle, and valid_id/valid_ex clear.
- halt_ex with valid_ex: one drain cycle with pc_we=0, then state=HALT with all enables 0. A later run_req resumes RUN.
- From IDLE, three step_req pulses: exactly three advancing cycles, and state returns to IDLE after each.
- rst asserted mid-RUN with counters at 5: state=IDLE, counters 0 immediately. With the macro undefined, counters stay 0 throughout.
